flatten_serializer: RTL and testbench

//  Parametrised parallel-to-serial flatten stage that feeds the FC layer. Captures one
//  CH-wide vector from the pooling stage and emits its CH elements one per beat, ch0 first.

---
 rtl/flatten_serializer_if.sv | 29 ++
 rtl/flatten_serializer.sv | 81 ++++++++
 tb/tb_flatten_serializer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/flatten_serializer_if.sv
// Handshake bundle between the pooling stage, the flatten serializer and the FC layer.
// The slave side is the serializer; the master side is whoever feeds frames and drains beats.
interface flatten_serializer_if #(
  parameter int CH = 32,
  parameter int DW = 8
);
  localparam int IDX_W = $clog2(CH);

  logic             in_valid;
  logic [CH*DW-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             busy;
  logic             overrun;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, busy, overrun
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, busy, overrun
  );
endinterface

// File: rtl/flatten_serializer.sv
// Parallel-to-serial flatten stage: captures a CH-wide frame and emits it one element per beat,
// ch0 first, with optional ping-pong banks so a new frame can land while the previous one drains.
module flatten_serializer #(
  parameter int CH       = 32,
  parameter int DW       = 8,
  parameter bit BUFFERED = 1'b1
) (
  input logic           clk,
  input logic           rst,
  flatten_serializer_if.slave bus
);
  localparam int IDX_W = $clog2(CH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_t;

  // Two banks are always declared; with BUFFERED=0 both pointers stay at bank 0 and bank 1 is dead.
  bank_state_t      state [2];
  logic [CH*DW-1:0] bank  [2];
  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] rd_idx;
  logic             overrun_q;

  logic [1:0]       full;
  logic [CH*DW-1:0] rd_word;
  logic             at_last;
  logic             capture;
  logic             xfer;

  always_comb begin
    full[0] = (state[0] == FULL);
    full[1] = (state[1] == FULL);
  end

  assign rd_word       = bank[rd_bank];
  assign at_last       = (rd_idx == IDX_W'(CH - 1));

  assign bus.in_ready  = !full[wr_bank];
  assign bus.out_valid = full[rd_bank];
  assign bus.out_data  = rd_word[int'(rd_idx) * DW +: DW];
  assign bus.out_idx   = rd_idx;
  assign bus.out_last  = full[rd_bank] && at_last;
  assign bus.busy      = |full;
  assign bus.overrun   = overrun_q;

  assign capture       = bus.in_valid && !full[wr_bank];
  assign xfer          = full[rd_bank] && bus.out_ready;

  // Capture and last-beat drain can share an edge: they always target different banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= EMPTY;
        bank[i]  <= '0;
      end
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      rd_idx    <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= bus.in_valid && full[wr_bank];
      if (xfer) begin
        if (at_last) begin
          rd_idx         <= '0;
          state[rd_bank] <= EMPTY;
          if (BUFFERED) rd_bank <= !rd_bank;
        end else begin
          rd_idx <= rd_idx + IDX_W'(1);
        end
      end
      if (capture) begin
        bank[wr_bank]  <= bus.in_data;
        state[wr_bank] <= FULL;
        if (BUFFERED) wr_bank <= !wr_bank;
      end
    end
  end
endmodule

// File: tb/tb_flatten_serializer.sv
// Bench for flatten_serializer: a ping-pong CH=32/DW=8 instance and a single-bank CH=4/DW=16
// instance, both checked beat by beat against a queue-of-elements reference model.
module tb_flatten_serializer;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  flatten_serializer_if #(.CH(32), .DW(8))  busA ();
  flatten_serializer_if #(.CH(4),  .DW(16)) busB ();

  flatten_serializer #(.CH(32), .DW(8), .BUFFERED(1'b1)) dutA (
    .clk(clk),
    .rst(rst),
    .bus(busA.slave)
  );

  flatten_serializer #(.CH(4), .DW(16), .BUFFERED(1'b0)) dutB (
    .clk(clk),
    .rst(rst),
    .bus(busB.slave)
  );

  typedef logic [15:0] frame_t [32];

  int          testCount = 0;
  int          failCount = 0;
  bit          sel;
  int          mCh;
  int          mCap;
  logic [15:0] mElems [$];
  logic        mOvr;
  frame_t      frm;
  frame_t      frmA;
  frame_t      frmB;
  frame_t      frmFF;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic randFrame(output frame_t f);
    for (int k = 0; k < 32; k++) f[k] = 16'($urandom);
  endtask

  task automatic setInputs(input bit iv, input frame_t f, input bit ordy);
    busA.in_valid  = sel ? 1'b0 : iv;
    busA.out_ready = sel ? 1'b0 : ordy;
    busB.in_valid  = sel ? iv : 1'b0;
    busB.out_ready = sel ? ordy : 1'b0;
    for (int k = 0; k < 32; k++) busA.in_data[k*8 +: 8] = f[k][7:0];
    for (int k = 0; k < 4; k++)  busB.in_data[k*16 +: 16] = f[k];
  endtask

  // One clock edge: the model holds the stream of undrained elements; stored frames and the
  // head index fall out of the queue length, a frame is accepted only while a bank is free.
  task automatic applyStimulus(input bit iv, input frame_t f, input bit ordy);
    int sz;
    int frames;
    bit expReady;
    bit expValid;
    setInputs(iv, f, ordy);
    sz       = mElems.size();
    frames   = (sz + mCh - 1) / mCh;
    expReady = (frames < mCap);
    expValid = (sz > 0);
    @(posedge clk);
    if (expValid && ordy) void'(mElems.pop_front());
    if (iv && expReady)
      for (int k = 0; k < mCh; k++) mElems.push_back(sel ? f[k] : {8'h00, f[k][7:0]});
    mOvr = iv && !expReady;
    #1;
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    setInputs(1'b0, frm, 1'b0);
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    mElems.delete();
    mOvr = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    logic [15:0] oData;
    logic [4:0]  oIdx;
    logic        oReady, oValid, oLast, oBusy, oOvr;
    int          sz;
    int          frames;
    int          head;
    if (sel) begin
      oData = busB.out_data;  oIdx = 5'(busB.out_idx);  oReady = busB.in_ready;
      oValid = busB.out_valid; oLast = busB.out_last;   oBusy = busB.busy; oOvr = busB.overrun;
    end else begin
      oData = {8'h00, busA.out_data}; oIdx = busA.out_idx; oReady = busA.in_ready;
      oValid = busA.out_valid; oLast = busA.out_last;   oBusy = busA.busy; oOvr = busA.overrun;
    end
    sz     = mElems.size();
    frames = (sz + mCh - 1) / mCh;
    head   = (mCh - (sz % mCh)) % mCh;
    cmp({tag, ".in_ready"},  oReady, frames < mCap);
    cmp({tag, ".out_valid"}, oValid, sz > 0);
    cmp({tag, ".busy"},      oBusy,  sz > 0);
    cmp({tag, ".overrun"},   oOvr,   mOvr);
    cmp({tag, ".out_idx"},   oIdx,   head);
    cmp({tag, ".out_last"},  oLast,  (sz > 0) && (sz % mCh == 1));
    if (sz > 0) cmp({tag, ".out_data"}, oData, mElems[0]);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sel = 1'b0; mCh = 32; mCap = 2; mOvr = 1'b0;
    for (int k = 0; k < 32; k++) begin
      frm[k]   = 16'h0000;
      frmFF[k] = 16'hFFFF;
    end

    doReset(2);
    checkOutput("reset");
    cmp("reset.data_zero", {24'h0, busA.out_data}, 32'h0);

    // Reset in the middle of a drain throws away the stored frame
    randFrame(frm);
    applyStimulus(1'b1, frm, 1'b1);
    repeat (5) applyStimulus(1'b0, frm, 1'b1);
    checkOutput("middrain");
    cmp("middrain.idx5", {27'h0, busA.out_idx}, 32'd5);
    doReset(2);
    checkOutput("midreset");
    cmp("midreset.data_zero", {24'h0, busA.out_data}, 32'h0);

    for (int k = 0; k < 32; k++) frm[k] = 16'(k + 1);
    applyStimulus(1'b1, frm, 1'b1);
    repeat (33) begin
      checkOutput("single");
      applyStimulus(1'b0, frm, 1'b1);
    end
    checkOutput("single.end");

    randFrame(frm);
    applyStimulus(1'b1, frm, 1'b0);
    for (int c = 0; c < 70; c++) begin
      checkOutput("backpressure");
      applyStimulus(1'b0, frm, c[0]);
    end
    checkOutput("backpressure.end");

    randFrame(frmA);
    randFrame(frmB);
    applyStimulus(1'b1, frmA, 1'b1);
    checkOutput("pingpong.a");
    applyStimulus(1'b0, frmA, 1'b1);
    applyStimulus(1'b0, frmA, 1'b1);
    applyStimulus(1'b1, frmB, 1'b1);
    for (int c = 0; c < 66; c++) begin
      checkOutput("pingpong");
      applyStimulus(1'b0, frmA, 1'b1);
    end

    // Both banks full, then an all-ones frame that must be dropped
    randFrame(frmA);
    randFrame(frmB);
    applyStimulus(1'b1, frmA, 1'b0);
    applyStimulus(1'b1, frmB, 1'b0);
    checkOutput("overrun.full");
    applyStimulus(1'b1, frmFF, 1'b0);
    checkOutput("overrun.pulse");
    cmp("overrun.seen", {31'h0, busA.overrun}, 32'd1);
    applyStimulus(1'b0, frmFF, 1'b0);
    checkOutput("overrun.gone");
    for (int c = 0; c < 66; c++) begin
      applyStimulus(1'b0, frmFF, 1'b1);
      checkOutput("overrun.drain");
    end

    for (int c = 0; c < 400; c++) begin
      randFrame(frm);
      applyStimulus($urandom_range(0, 3) == 0, frm, $urandom_range(0, 3) != 0);
      checkOutput("randomA");
    end

    sel = 1'b1; mCh = 4; mCap = 1;
    doReset(1);
    checkOutput("b.reset");
    randFrame(frmA);
    randFrame(frmB);
    applyStimulus(1'b1, frmA, 1'b1);
    for (int c = 0; c < 5; c++) begin
      checkOutput("b.offer");
      applyStimulus(1'b1, frmB, 1'b1);
    end
    for (int c = 0; c < 6; c++) begin
      checkOutput("b.drain");
      applyStimulus(1'b0, frmB, 1'b1);
    end

    for (int c = 0; c < 200; c++) begin
      randFrame(frm);
      applyStimulus($urandom_range(0, 2) == 0, frm, $urandom_range(0, 3) != 0);
      checkOutput("randomB");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
